// File: rtl/array_2d_check.sv
// array_2d_check: WA x WC array with clear/fill/check sequencer reporting the first mismatch in scan order.
// Optional mismatch counter output err_cnt enabled by defining ARRAY_2D_CHECK_ERRCNT_EN.
module array_2d_check #(
   parameter int WA = 4,
   parameter int WC = 4,
   parameter int WB = 8,
   parameter int DESC = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     fill,
   input  logic [$clog2(WA+1)-1:0]  wa_cfg,
   input  logic [$clog2(WC+1)-1:0]  wc_cfg,
   input  logic                     ext_we,
   input  logic [$clog2(WA)-1:0]    ext_a,
   input  logic [$clog2(WC)-1:0]    ext_c,
   input  logic [WB-1:0]            ext_d,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [$clog2(WA)-1:0]    fail_a,
   output logic [$clog2(WC)-1:0]    fail_c
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
   ,
   output logic [$clog2(WA*WC+1)-1:0] err_cnt
`endif
);
   localparam int AW = $clog2(WA);
   localparam int CW = $clog2(WC);
   localparam int AL = $clog2(WA+1);
   localparam int CL = $clog2(WC+1);
   localparam int NW = $clog2(WA*WC+2);
   localparam int HW = WB/2;
   localparam int N  = WA*WC;
   typedef enum logic [2:0] {IDLE, CLEAR, FILL, CHECK, DONE} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] a_q, a_d, pa_q, fa_q, fa_d, sa, na, fill_a;
   logic [CW-1:0] c_q, c_d, pc_q, fc_q, fc_d, sc, nc, fill_c;
   logic [NW-1:0] n_q, n_d, area;
   logic [AL-1:0] wa_q, wa_d, la;
   logic [CL-1:0] wc_q, wc_d, lc;
   logic [WB-1:0] mem_q [WA][WC];
   logic [WB-1:0] rd_q, exp_v, wd;
   logic          v_q, v_d, seen_q, seen_d, pass_q, pass_d, mism, we, acc;
   logic [AW-1:0] wadr;
   logic [CW-1:0] wcdr;
   always_comb begin
      acc    = state_q == IDLE && start;
      area   = NW'(wa_q) * NW'(wc_q);
      la     = state_q == FILL ? wa_q : AL'(WA);
      lc     = state_q == FILL ? wc_q : CL'(WC);
      sa     = DESC != 0 ? AW'(WA-1) : '0;
      sc     = DESC != 0 ? CW'(WC-1) : '0;
      fill_a = DESC != 0 ? AW'(wa_q - 1'b1) : '0;
      fill_c = DESC != 0 ? CW'(wc_q - 1'b1) : '0;
      // Row-major stepping; descending walks the same path backwards
      if (DESC != 0) begin
         na = c_q == '0 ? a_q - 1'b1 : a_q;
         nc = c_q == '0 ? CW'(lc - 1'b1) : c_q - 1'b1;
      end else begin
         na = CL'(c_q) == lc - 1'b1 ? a_q + 1'b1 : a_q;
         nc = CL'(c_q) == lc - 1'b1 ? '0 : c_q + 1'b1;
      end
      exp_v  = (AL'(pa_q) < wa_q && CL'(pc_q) < wc_q) ? {HW'(pa_q), HW'(pc_q)} : '0;
      mism   = v_q && rd_q != exp_v;
      we     = rst_n && ((state_q == IDLE && ext_we && ext_a <= AW'(WA-1) && ext_c <= CW'(WC-1))
                         || state_q == CLEAR || state_q == FILL);
      wadr   = state_q == IDLE ? ext_a : a_q;
      wcdr   = state_q == IDLE ? ext_c : c_q;
      wd     = state_q == IDLE ? ext_d : state_q == CLEAR ? '0 : {HW'(a_q), HW'(c_q)};
      v_d    = state_q == CHECK && n_q < NW'(N);
      state_d = state_q;
      n_d    = n_q + 1'b1;
      a_d    = na;
      c_d    = nc;
      wa_d   = wa_q;
      wc_d   = wc_q;
      seen_d = seen_q | mism;
      fa_d   = mism && !seen_q ? pa_q : fa_q;
      fc_d   = mism && !seen_q ? pc_q : fc_q;
      pass_d = pass_q;
      case (state_q)
         IDLE: begin
            n_d = '0;
            a_d = a_q;
            c_d = c_q;
            if (start) begin
               state_d = fill ? CLEAR : CHECK;
               a_d     = sa;
               c_d     = sc;
               wa_d    = wa_cfg > AL'(WA) ? AL'(WA) : wa_cfg;
               wc_d    = wc_cfg > CL'(WC) ? CL'(WC) : wc_cfg;
               seen_d  = 1'b0;
               fa_d    = '0;
               fc_d    = '0;
               pass_d  = 1'b0;
            end
         end
         CLEAR: if (n_q == NW'(N-1)) begin
            n_d     = '0;
            state_d = area == '0 ? CHECK : FILL;
            a_d     = area == '0 ? sa : fill_a;
            c_d     = area == '0 ? sc : fill_c;
         end
         FILL: if (n_q == area - 1'b1) begin
            n_d     = '0;
            state_d = CHECK;
            a_d     = sa;
            c_d     = sc;
         end
         CHECK: if (n_q == NW'(N)) begin
            state_d = DONE;
            pass_d  = !(seen_q | mism);
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (we) mem_q[wadr][wcdr] <= wd;
      rd_q <= mem_q[a_q][c_q];
      pa_q <= a_q;
      pc_q <= c_q;
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         a_q     <= '0;
         c_q     <= '0;
         wa_q    <= '0;
         wc_q    <= '0;
         v_q     <= 1'b0;
         seen_q  <= 1'b0;
         fa_q    <= '0;
         fc_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         a_q     <= a_d;
         c_q     <= c_d;
         wa_q    <= wa_d;
         wc_q    <= wc_d;
         v_q     <= v_d;
         seen_q  <= seen_d;
         fa_q    <= fa_d;
         fc_q    <= fc_d;
         pass_q  <= pass_d;
      end
   end
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
   localparam int EW = $clog2(WA*WC+1);
   logic [EW-1:0] ec_q, ec_d;
   always_comb ec_d = acc ? '0 : (mism && ec_q != EW'(N)) ? ec_q + 1'b1 : ec_q;
   always_ff @(posedge clk) begin
      if (!rst_n) ec_q <= '0;
      else ec_q <= ec_d;
   end
   assign err_cnt = ec_q;
`else
   logic unused_acc;
   assign unused_acc = acc;
`endif
   assign busy   = state_q != IDLE;
   assign done   = state_q == DONE;
   assign pass   = pass_q;
   assign fail_a = fa_q;
   assign fail_c = fc_q;
endmodule

// File: tb/tb_array_2d_check.sv
// tb_array_2d_check: directed checks of two array_2d_check instances (ascending and descending scan).
module tb_array_2d_check;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, fill = 1'b0, ext_we = 1'b0;
   logic [2:0] wa_cfg = '0, wc_cfg = '0;
   logic [1:0] ext_a = '0, ext_c = '0;
   logic [7:0] ext_d = '0;
   logic busy0, done0, pass0, busy1, done1, pass1;
   logic [1:0] fa0, fc0, fa1, fc1;
   int checks = 0, failures = 0;
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
   logic [4:0] ec0, ec1;
`endif
   always #5 clk = ~clk;
   array_2d_check #(.WA(4), .WC(4), .WB(8), .DESC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .fill(fill), .wa_cfg(wa_cfg), .wc_cfg(wc_cfg),
      .ext_we(ext_we), .ext_a(ext_a), .ext_c(ext_c), .ext_d(ext_d),
      .busy(busy0), .done(done0), .pass(pass0), .fail_a(fa0), .fail_c(fc0)
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
      , .err_cnt(ec0)
`endif
   );
   array_2d_check #(.WA(4), .WC(4), .WB(8), .DESC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .fill(fill), .wa_cfg(wa_cfg), .wc_cfg(wc_cfg),
      .ext_we(ext_we), .ext_a(ext_a), .ext_c(ext_c), .ext_d(ext_d),
      .busy(busy1), .done(done1), .pass(pass1), .fail_a(fa1), .fail_c(fc1)
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
      , .err_cnt(ec1)
`endif
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Start a run; report the cycle (1 = first cycle after the start edge) of each done and how many done cycles were seen
   task automatic run(input logic f, input logic [2:0] wa, input logic [2:0] wc, input int inj,
                      output int c0, output int c1, output int n0, output int n1, output logic clr);
      c0 = 0; c1 = 0; n0 = 0; n1 = 0; clr = 1'b0;
      start = 1'b1; fill = f; wa_cfg = wa; wc_cfg = wc;
      step();
      start = 1'b0; fill = 1'b0; wa_cfg = '0; wc_cfg = '0;
      for (int k = 1; k <= 120; k++) begin
         if (k == 1) clr = busy0 && busy1 && !pass0 && !pass1 && fa0 == 0 && fc0 == 0 && fa1 == 0 && fc1 == 0;
         if (done0) begin if (c0 == 0) c0 = k; n0++; end
         if (done1) begin if (c1 == 0) c1 = k; n1++; end
         if (c0 != 0 && c1 != 0 && k >= c0 + 4 && k >= c1 + 4) break;
         if (k == inj) begin
            start = 1'b1; fill = 1'b1; wa_cfg = 3'd1; wc_cfg = 3'd1;
            ext_we = 1'b1; ext_a = 2'd0; ext_c = 2'd0; ext_d = 8'hff;
         end else begin
            start = 1'b0; fill = 1'b0; wa_cfg = '0; wc_cfg = '0; ext_we = 1'b0;
         end
         step();
      end
      start = 1'b0; ext_we = 1'b0;
   endtask
   task automatic ext_wr(input logic [1:0] a, input logic [1:0] c, input logic [7:0] d);
      ext_we = 1'b1; ext_a = a; ext_c = c; ext_d = d;
      step();
      ext_we = 1'b0;
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      checks++;
      if ({busy0, done0, pass0, fa0, fc0, busy1, done1, pass1, fa1, fc1} !== 12'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=0", {busy0, done0, pass0, fa0, fc0, busy1, done1, pass1, fa1, fc1});
      end
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
      checks++;
      if (ec0 !== 5'd0 || ec1 !== 5'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d/%0d want=0", ec0, ec1); end
`endif
   endtask
   task automatic test_fill_check();
      int c0, c1, n0, n1;
      logic clr;
      run(1'b1, 3'd2, 3'd3, 0, c0, c1, n0, n1, clr);
      checks++;
      if (c0 !== 40 || c1 !== 40) begin failures++; $display("FAIL fill_done_cycle got=%0d/%0d want=40", c0, c1); end
      checks++;
      if (n0 !== 1 || n1 !== 1) begin failures++; $display("FAIL fill_done_pulses got=%0d/%0d want=1", n0, n1); end
      checks++;
      if (pass0 !== 1'b1 || pass1 !== 1'b1 || busy0 !== 1'b0) begin
         failures++; $display("FAIL fill_pass got=%b%b busy=%b want=11 busy=0", pass0, pass1, busy0);
      end
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
      checks++;
      if (ec0 !== 5'd0 || ec1 !== 5'd0) begin failures++; $display("FAIL fill_err_cnt got=%0d/%0d want=0", ec0, ec1); end
`endif
   endtask
   task automatic test_ext_mismatch();
      int c0, c1, n0, n1;
      logic clr;
      ext_wr(2'd1, 2'd2, 8'h00);
      run(1'b0, 3'd2, 3'd3, 0, c0, c1, n0, n1, clr);
      checks++;
      if (c0 !== 18 || c1 !== 18) begin failures++; $display("FAIL chk_done_cycle got=%0d/%0d want=18", c0, c1); end
      checks++;
      if (pass0 !== 1'b0 || fa0 !== 2'd1 || fc0 !== 2'd2) begin
         failures++; $display("FAIL asc_first_miss got=%b (%0d,%0d) want=0 (1,2)", pass0, fa0, fc0);
      end
      checks++;
      if (pass1 !== 1'b0 || fa1 !== 2'd1 || fc1 !== 2'd2) begin
         failures++; $display("FAIL desc_single_miss got=%b (%0d,%0d) want=0 (1,2)", pass1, fa1, fc1);
      end
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
      checks++;
      if (ec0 !== 5'd1 || ec1 !== 5'd1) begin failures++; $display("FAIL one_err_cnt got=%0d/%0d want=1", ec0, ec1); end
`endif
   endtask
   task automatic test_desc();
      int c0, c1, n0, n1;
      logic clr;
      ext_wr(2'd3, 2'd3, 8'h55);
      run(1'b0, 3'd2, 3'd3, 0, c0, c1, n0, n1, clr);
      checks++;
      if (clr !== 1'b1) begin failures++; $display("FAIL start_clears_result got=%b want=1", clr); end
      checks++;
      if (fa0 !== 2'd1 || fc0 !== 2'd2) begin failures++; $display("FAIL asc_keeps_first got=(%0d,%0d) want=(1,2)", fa0, fc0); end
      checks++;
      if (pass1 !== 1'b0 || fa1 !== 2'd3 || fc1 !== 2'd3) begin
         failures++; $display("FAIL desc_first_miss got=%b (%0d,%0d) want=0 (3,3)", pass1, fa1, fc1);
      end
`ifdef ARRAY_2D_CHECK_ERRCNT_EN
      checks++;
      if (ec0 !== 5'd2 || ec1 !== 5'd2) begin failures++; $display("FAIL two_err_cnt got=%0d/%0d want=2", ec0, ec1); end
`endif
   endtask
   task automatic test_clamp();
      int c0, c1, n0, n1;
      logic clr;
      run(1'b1, 3'd7, 3'd0, 0, c0, c1, n0, n1, clr);
      checks++;
      if (c0 !== 34 || c1 !== 34) begin failures++; $display("FAIL clamp_done_cycle got=%0d/%0d want=34", c0, c1); end
      checks++;
      if (pass0 !== 1'b1 || pass1 !== 1'b1 || fa0 !== 2'd0 || fc0 !== 2'd0) begin
         failures++; $display("FAIL clamp_pass got=%b%b (%0d,%0d) want=11 (0,0)", pass0, pass1, fa0, fc0);
      end
   endtask
   task automatic test_reset_abort();
      int c0, c1, n0, n1, seen;
      logic clr;
      start = 1'b1; fill = 1'b1; wa_cfg = 3'd4; wc_cfg = 3'd4;
      step();
      start = 1'b0; fill = 1'b0;
      for (int k = 1; k < 20; k++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
         failures++; $display("FAIL abort_idle got busy=%b%b done=%b%b want=0", busy0, busy1, done0, done1);
      end
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         if (done0 || done1 || busy0 || busy1) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d active cycles want=0", seen); end
      run(1'b1, 3'd4, 3'd4, 0, c0, c1, n0, n1, clr);
      checks++;
      if (c0 !== 50 || c1 !== 50 || pass0 !== 1'b1 || pass1 !== 1'b1) begin
         failures++; $display("FAIL rerun_after_abort got cyc=%0d/%0d pass=%b%b want=50 11", c0, c1, pass0, pass1);
      end
   endtask
   task automatic test_busy_ignore();
      int c0, c1, n0, n1;
      logic clr;
      run(1'b1, 3'd2, 3'd3, 0, c0, c1, n0, n1, clr);
      run(1'b0, 3'd2, 3'd3, 5, c0, c1, n0, n1, clr);
      checks++;
      if (c0 !== 18 || c1 !== 18 || n0 !== 1 || n1 !== 1 || busy0 !== 1'b0) begin
         failures++; $display("FAIL busy_no_restart got cyc=%0d/%0d pulses=%0d/%0d busy=%b want=18 1 0", c0, c1, n0, n1, busy0);
      end
      checks++;
      if (pass0 !== 1'b1 || pass1 !== 1'b1) begin failures++; $display("FAIL busy_result got=%b%b want=11", pass0, pass1); end
      run(1'b0, 3'd2, 3'd3, 0, c0, c1, n0, n1, clr);
      checks++;
      if (pass0 !== 1'b1 || pass1 !== 1'b1) begin failures++; $display("FAIL busy_array_kept got=%b%b want=11", pass0, pass1); end
   endtask
   initial begin
      #1;
      test_reset();
      test_fill_check();
      test_ext_mismatch();
      test_desc();
      test_clamp();
      test_reset_abort();
      test_busy_ignore();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
